// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: NUM_CORES single-beat DMA request ports onto one host-memory port, with in-order read-response routing.
// Latency: grant is combinational with the memory handshake (0 cycles); read responses reach the core 1 cycle after mem_rvalid.
// Backpressure: mem_ready low stalls all grants; reads become ineligible while the tag FIFO is full, but writes still flow.
// Optional stall-cycle counter is built only when ARB_STATS_EN is defined; otherwise stat_stall_cycles is tied to 0.

// Tag FIFO holding core IDs of outstanding reads, in issue order.
// Latency: head visible combinationally; push/pop take effect on the next clock edge.
// Backpressure: push ignored when full, pop ignored when empty; caller must check full/empty.
module mem_arbiter_rr_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (cnt_q == CNT_MAX);
    assign empty    = (cnt_q == '0);
    assign push_ok  = push_vld & ~full;
    assign pop_ok   = pop_rdy & ~empty;
    assign head_dat = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Pointer/occupancy registers; reset discards every stored tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// Top: round-robin selection, memory-port mux, tag tracking and response demux.
// Latency: core_gnt same cycle as mem_req & mem_ready; core_valid/core_rdata registered one cycle after mem_rvalid.
// Backpressure: no grant without mem_ready; read eligibility gated by tag FIFO full (a same-cycle pop does not help).
module mem_arbiter_rr #(
    parameter int NUM_CORES = 4,
    parameter int TAG_DEPTH = 8,
    parameter int ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      core_req,
    input  logic [NUM_CORES-1:0]      core_we,
    input  logic [NUM_CORES*48-1:0]   core_addr,
    input  logic [NUM_CORES*64-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]      core_gnt,
    output logic [NUM_CORES-1:0]      core_valid,
    output logic [63:0]               core_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [47:0]               mem_addr,
    output logic [63:0]               mem_wdata,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [63:0]               mem_rdata,
    output logic                      err_orphan,
    output logic [31:0]               stat_stall_cycles
);
    localparam int ADDR_W = 48;
    localparam int DATA_W = 64;
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_CORES - 1);

    // Arbitration state
    logic [ID_W-1:0]      last_q, last_d;
    logic [NUM_CORES-1:0] elig;
    logic                 any_elig;
    logic [ID_W-1:0]      sel;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 xfer;

    // Tag FIFO interface
    logic                 tag_push;
    logic [ID_W-1:0]      tag_head;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 rsp_hit;

    // Response registers
    logic [NUM_CORES-1:0] core_valid_q, core_valid_d;
    logic [DATA_W-1:0]    core_rdata_q, core_rdata_d;
    logic                 err_orphan_q, err_orphan_d;

    // Eligibility: writes always, reads only with a free tag slot; nothing is eligible while in reset.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            elig[i] = core_req[i] & (core_we[i] | ~tag_full) & ~rst;
        end
    end

    // Round-robin pick: first eligible core scanning from last+1, wrapping; the winner's fields are muxed out.
    always_comb begin
        any_elig  = 1'b0;
        sel       = last_q;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!any_elig && elig[i] && (i == ((int'(last_q) + k) % NUM_CORES))) begin
                    any_elig  = 1'b1;
                    sel       = ID_W'(i);
                    sel_we    = core_we[i];
                    sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                    sel_wdata = core_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign mem_req   = any_elig;
    assign mem_we    = sel_we;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;
    assign xfer      = mem_req & mem_ready;
    assign tag_push  = xfer & ~sel_we;

    // Grant is the memory handshake itself, steered to the selected core.
    always_comb begin
        core_gnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_gnt[i] = xfer & (sel == ID_W'(i));
        end
    end

    // Every accepted transfer moves the priority pointer, so even a repeating requester rotates.
    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = sel;
        end
    end

    // Priority pointer register; starts at the highest index so core 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

    mem_arbiter_rr_fifo #(
        .W     (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (tag_push),
        .push_dat (sel),
        .pop_rdy  (mem_rvalid),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    assign rsp_hit = mem_rvalid & ~tag_empty;

    // Response demux: a matched response strobes the head core; an unmatched one is dropped and flagged.
    always_comb begin
        core_valid_d = '0;
        core_rdata_d = core_rdata_q;
        err_orphan_d = err_orphan_q | (mem_rvalid & tag_empty);
        for (int i = 0; i < NUM_CORES; i++) begin
            core_valid_d[i] = rsp_hit & (tag_head == ID_W'(i));
        end
        if (rsp_hit) begin
            core_rdata_d = mem_rdata;
        end
    end

    // Response and error registers; err_orphan is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid_q <= '0;
            core_rdata_q <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            core_valid_q <= core_valid_d;
            core_rdata_q <= core_rdata_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign core_valid = core_valid_q;
    assign core_rdata = core_rdata_q;
    assign err_orphan = err_orphan_q;

`ifdef ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where some requesting core was left waiting; saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|(core_req & ~core_gnt)) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_stall_cycles = stall_cnt_q;
`else
    assign stat_stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with hand-computed expectations.
// Inputs change just after the falling edge; everything is sampled 1 time unit later, well clear of the rising edge.
module tb_mem_arbiter_rr;
    localparam int NC = 4;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_we;
    logic [NC*48-1:0]  core_addr;
    logic [NC*64-1:0]  core_wdata;
    logic [NC-1:0]     core_gnt;
    logic [NC-1:0]     core_valid;
    logic [63:0]       core_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [47:0]       mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;
    logic              err_orphan;
    logic [31:0]       stat_stall_cycles;

    int total;
    int bad;

    mem_arbiter_rr #(
        .NUM_CORES (NC),
        .TAG_DEPTH (8),
        .ID_W      (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .core_req          (core_req),
        .core_we           (core_we),
        .core_addr         (core_addr),
        .core_wdata        (core_wdata),
        .core_gnt          (core_gnt),
        .core_valid        (core_valid),
        .core_rdata        (core_rdata),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ready         (mem_ready),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .err_orphan        (err_orphan),
        .stat_stall_cycles (stat_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int i, input logic req, input logic we,
                            input logic [47:0] a, input logic [63:0] d);
        core_req[i]             = req;
        core_we[i]              = we;
        core_addr[i*48 +: 48]   = a;
        core_wdata[i*64 +: 64]  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_v;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt",   64'(core_gnt), 64'h0);
        chk("rst_valid", 64'(core_valid), 64'h0);
        chk("rst_rdata", core_rdata, 64'h0);
        chk("rst_err",   64'(err_orphan), 64'h0);
        chk("rst_stat",  64'(stat_stall_cycles), 64'h0);
        chk("rst_mreq",  64'(mem_req), 64'h0);
        rst = 1'b0;

        // Cores 0 and 2 writing: grants alternate 0,2,0,2 and the address follows
        @(negedge clk);
        set_core(0, 1'b1, 1'b1, 48'h100, 64'h1111);
        set_core(2, 1'b1, 1'b1, 48'h300, 64'h3333);
        mem_ready = 1'b1;
        #1;
        chk("wr_gnt0",   64'(core_gnt), 64'h1);
        chk("wr_addr0",  64'(mem_addr), 64'h100);
        chk("wr_we0",    64'(mem_we), 64'h1);
        chk("wr_wdata0", mem_wdata, 64'h1111);
        @(negedge clk); #1;
        chk("wr_gnt1",   64'(core_gnt), 64'h4);
        chk("wr_addr1",  64'(mem_addr), 64'h300);
        chk("wr_wdata1", mem_wdata, 64'h3333);
        @(negedge clk); #1;
        chk("wr_gnt2",   64'(core_gnt), 64'h1);
        chk("wr_addr2",  64'(mem_addr), 64'h100);
        @(negedge clk); #1;
        chk("wr_gnt3",   64'(core_gnt), 64'h4);
        chk("wr_addr3",  64'(mem_addr), 64'h300);
        @(negedge clk);
        set_core(0, 1'b0, 1'b0, 48'h0, 64'h0);
        set_core(2, 1'b0, 1'b0, 48'h0, 64'h0);
        #1;
        chk("idle_mreq",  64'(mem_req), 64'h0);
        chk("idle_maddr", 64'(mem_addr), 64'h0);
        chk("idle_gnt",   64'(core_gnt), 64'h0);

        // Core 1 read of 0x1000; memory answers 3 cycles after accept
        @(negedge clk);
        set_core(1, 1'b1, 1'b0, 48'h1000, 64'h0);
        #1;
        chk("rd_gnt",  64'(core_gnt), 64'h2);
        chk("rd_we",   64'(mem_we), 64'h0);
        chk("rd_addr", 64'(mem_addr), 64'h1000);
        @(negedge clk);
        set_core(1, 1'b0, 1'b0, 48'h0, 64'h0);
        #1;
        chk("rd_gnt_off", 64'(core_gnt), 64'h0);
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD;
        #1;
        chk("rd_valid_early", 64'(core_valid), 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("rd_valid", 64'(core_valid), 64'h2);
        chk("rd_rdata", core_rdata, 64'hDEAD);
        @(negedge clk); #1;
        chk("rd_valid_drop", 64'(core_valid), 64'h0);

        // Reads from cores 0, 1, 3 in that order; responses routed in order
        @(negedge clk);
        set_core(0, 1'b1, 1'b0, 48'h2000, 64'h0);
        #1;
        chk("ord_gnt0", 64'(core_gnt), 64'h1);
        @(negedge clk);
        set_core(0, 1'b0, 1'b0, 48'h0, 64'h0);
        set_core(1, 1'b1, 1'b0, 48'h2100, 64'h0);
        #1;
        chk("ord_gnt1", 64'(core_gnt), 64'h2);
        @(negedge clk);
        set_core(1, 1'b0, 1'b0, 48'h0, 64'h0);
        set_core(3, 1'b1, 1'b0, 48'h2300, 64'h0);
        #1;
        chk("ord_gnt3", 64'(core_gnt), 64'h8);
        @(negedge clk);
        set_core(3, 1'b0, 1'b0, 48'h0, 64'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hA;
        @(negedge clk); #1;
        chk("ord_v0", 64'(core_valid), 64'h1);
        chk("ord_d0", core_rdata, 64'hA);
        mem_rdata = 64'hB;
        @(negedge clk); #1;
        chk("ord_v1", 64'(core_valid), 64'h2);
        chk("ord_d1", core_rdata, 64'hB);
        mem_rdata = 64'hC;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("ord_v3", 64'(core_valid), 64'h8);
        chk("ord_d3", core_rdata, 64'hC);
        @(negedge clk); #1;
        chk("ord_vdrop", 64'(core_valid), 64'h0);

        // Fill all 8 tags with back-to-back reads from core 0
        @(negedge clk);
        set_core(0, 1'b1, 1'b0, 48'h4000, 64'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("fill_gnt%0d", k), 64'(core_gnt), 64'h1);
            @(negedge clk);
        end
        // Full: core 2 read blocked, core 3 write still granted
        set_core(0, 1'b0, 1'b0, 48'h0, 64'h0);
        set_core(2, 1'b1, 1'b0, 48'h4200, 64'h0);
        set_core(3, 1'b1, 1'b1, 48'h4300, 64'h33);
        #1;
        chk("full_gnt",  64'(core_gnt), 64'h8);
        chk("full_we",   64'(mem_we), 64'h1);
        chk("full_addr", 64'(mem_addr), 64'h4300);
        @(negedge clk);
        set_core(3, 1'b0, 1'b0, 48'h0, 64'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h11;
        #1;
        chk("full_pop_gnt",  64'(core_gnt), 64'h0);
        chk("full_pop_mreq", 64'(mem_req), 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("reen_valid", 64'(core_valid), 64'h1);
        chk("reen_rdata", core_rdata, 64'h11);
        chk("reen_gnt",   64'(core_gnt), 64'h4);
        chk("reen_addr",  64'(mem_addr), 64'h4200);
        @(negedge clk);
        set_core(2, 1'b0, 1'b0, 48'h0, 64'h0);
        // Drain: seven core-0 tags, then the core-2 tag
        for (int k = 0; k < 8; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'h20 + 64'(k);
            exp_v      = (k == 7) ? 4'h4 : 4'h1;
            @(negedge clk); #1;
            chk($sformatf("drain_v%0d", k), 64'(core_valid), 64'(exp_v));
            chk($sformatf("drain_d%0d", k), core_rdata, 64'h20 + 64'(k));
        end
        mem_rvalid = 1'b0;
        @(negedge clk); #1;
        chk("drain_vdrop", 64'(core_valid), 64'h0);
        chk("drain_err",   64'(err_orphan), 64'h0);

        // Orphan response: flagged, dropped, sticky
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h99;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("orph_err",   64'(err_orphan), 64'h1);
        chk("orph_valid", 64'(core_valid), 64'h0);
        chk("orph_rdata", core_rdata, 64'h27);
        @(negedge clk); #1;
        chk("orph_sticky", 64'(err_orphan), 64'h1);

        // Reset with a read outstanding and a write pending
        @(negedge clk);
        set_core(1, 1'b1, 1'b0, 48'h5000, 64'h0);
        #1;
        chk("mid_gnt", 64'(core_gnt), 64'h2);
        @(negedge clk);
        set_core(1, 1'b0, 1'b0, 48'h0, 64'h0);
        set_core(2, 1'b1, 1'b1, 48'h5200, 64'h52);
        rst = 1'b1;
        #1;
        chk("mrst_gnt",   64'(core_gnt), 64'h0);
        chk("mrst_mreq",  64'(mem_req), 64'h0);
        chk("mrst_addr",  64'(mem_addr), 64'h0);
        chk("mrst_wdata", mem_wdata, 64'h0);
        chk("mrst_valid", 64'(core_valid), 64'h0);
        chk("mrst_rdata", core_rdata, 64'h0);
        chk("mrst_err",   64'(err_orphan), 64'h0);
        chk("mrst_stat",  64'(stat_stall_cycles), 64'h0);
        @(negedge clk);
        set_core(2, 1'b0, 1'b0, 48'h0, 64'h0);
        rst = 1'b0;
        // The pre-reset read's response is now an orphan
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h77;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("post_rst_err",   64'(err_orphan), 64'h1);
        chk("post_rst_valid", 64'(core_valid), 64'h0);

        // All four cores write for 10 cycles: grants rotate 0..3, three cores stall each cycle
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            set_core(i, 1'b1, 1'b1, 48'h6000 + 48'(i), 64'(i));
        end
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_v = 4'(1 << (k % 4));
            chk($sformatf("rot_gnt%0d", k), 64'(core_gnt), 64'(exp_v));
            @(negedge clk);
        end
        for (int i = 0; i < NC; i++) begin
            set_core(i, 1'b0, 1'b0, 48'h0, 64'h0);
        end
        #1;
`ifdef ARB_STATS_EN
        chk("stat_stall", 64'(stat_stall_cycles), 64'd10);
`else
        chk("stat_tied0", 64'(stat_stall_cycles), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Round-robin arbiter between NUM_CORES NTT engine DMA ports and a single host-memory port.
- Sits directly downstream of the engines' arb_* interface.
- Accepts single-beat read and write requests and forwards them to memory.
- Routes in-order read responses back to the issuing core using a tag FIFO of core IDs.

Parameters:
- NUM_CORES, 4, number of engine request ports (2..16)
- TAG_DEPTH, 8, max outstanding reads (power of 2)
- ID_W, 2, core-ID width; must be at least clog2(NUM_CORES)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- core_req  in  NUM_CORES  per-core request
- core_we  in  NUM_CORES  per-core write enable
- core_addr  in  NUM_CORES*48  per-core byte address, core i at bits [48i+47:48i]
- core_wdata  in  NUM_CORES*64  per-core write data
- core_gnt  out  NUM_CORES  one-hot accept pulse
- core_valid  out  NUM_CORES  one-hot read-response strobe
- core_rdata  out  64  read data, broadcast to all cores
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  48  memory address
- mem_wdata  out  64  memory write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read response valid (in order)
- mem_rdata  in  64  read response data
- err_orphan  out  1  sticky: a response arrived with no outstanding read
- stat_stall_cycles  out  32  conflict counter (optional feature)

Behaviour:
- Reset values:
  - core_gnt=0, core_valid=0, core_rdata=0, err_orphan=0, stat_stall_cycles=0.
  - Tag FIFO empty; last-grant pointer = NUM_CORES-1, so core 0 wins first.
- Eligibility: core i is eligible when core_req[i]=1 and (core_we[i]=1 or tag FIFO not full).
- Selection (combinational): sel = first eligible core scanning from last+1 modulo NUM_CORES.
- Memory outputs:
  - mem_req = 1 when any core is eligible.
  - mem_we, mem_addr, mem_wdata are muxed from sel.
  - When mem_req=0, the data outputs are 0.
- Grant and transfer:
  - core_gnt[sel] = mem_req & mem_ready; this is the same cycle as the memory handshake, zero latency.
  - A transfer occurs on mem_req & mem_ready.
  - On a transfer, last <= sel. A read transfer also pushes sel into the tag FIFO.
- Every transfer rotates priority, including back-to-back writes from the same core. A sole requester may still be granted every cycle.
- Reads: a core holds req until its gnt pulse, then drops it. The gnt pulse is exactly one cycle per accepted request.
- Responses:
  - On mem_rvalid with FIFO non-empty: pop the head ID, core_valid[ID] <= 1 and core_rdata <= mem_rdata, registered.
  - Response latency is therefore one cycle after mem_rvalid. core_valid deasserts the following cycle unless another response arrives.
- FIFO full: read requests are not eligible even if a pop occurs in the same cycle. Writes remain eligible.
- Orphan response: mem_rvalid with FIFO empty sets err_orphan, the data is dropped and no core_valid is raised. err_orphan clears only on rst.
- Simultaneous read push and response pop in the same cycle: both occur and the count is unchanged.
- Reset mid-operation: all outstanding tags are discarded. Responses arriving afterwards raise err_orphan.
- Writes carry no response tag; memory never returns rvalid for writes.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: stat_stall_cycles increments (saturating at 2^32-1) on every cycle where at least one core with core_req=1 receives no gnt.
- Undefined: stat_stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Cores 0 and 2 hold write requests with mem_ready=1 -> gnt alternates 0,2,0,2 on consecutive cycles; mem_addr follows the granted core each cycle.
- Core 1 reads addr 0x1000, memory returns 0xDEAD 3 cycles after accept -> core_valid=4'b0010 and core_rdata=0xDEAD one cycle after mem_rvalid.
- Cores 0, 1 and 3 read in order 0,1,3; memory responds 0xA, 0xB, 0xC in order -> core_valid pulses cores 0, 1, 3 with data 0xA, 0xB, 0xC respectively.
- 8 outstanding reads with no responses, then core 2 read and core 3 write -> core 2 gets no gnt and core 3 is granted; the first response re-enables core 2.
- mem_rvalid with nothing outstanding -> err_orphan=1 stays high and no core_valid; assert rst mid-transfer -> all outputs return to 0.
- With ARB_STATS_EN, 4 cores all requesting writes for 10 cycles -> stat_stall_cycles=10.
